traffic_controller_ped: RTL and testbench



---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/phase_timer.sv | 32 +++
 rtl/traffic_controller_ped.sv | 169 ++++++++++++++++
 tb/tb_traffic_controller_ped.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic controller with pedestrian phase.
// Contents: phase state codes, lamp bit positions, and the 6-bit lamp patterns
// {A_red, A_yel, A_grn, B_red, B_yel, B_grn} driven by each phase.
package traffic_pkg;

   typedef enum logic [2:0] {
      StBg    = 3'd0,
      StBy    = 3'd1,
      StAr1   = 3'd2,
      StAg    = 3'd3,
      StAy    = 3'd4,
      StAr2   = 3'd5,
      StPed   = 3'd6,
      StFlash = 3'd7
   } state_e;

   localparam int unsigned LA_RED = 5;
   localparam int unsigned LA_YEL = 4;
   localparam int unsigned LA_GRN = 3;
   localparam int unsigned LB_RED = 2;
   localparam int unsigned LB_YEL = 1;
   localparam int unsigned LB_GRN = 0;

   function automatic logic [5:0] lamp(input logic a_r, input logic a_y, input logic a_g,
                                       input logic b_r, input logic b_y, input logic b_g);
      logic [5:0] l;
      l         = '0;
      l[LA_RED] = a_r;
      l[LA_YEL] = a_y;
      l[LA_GRN] = a_g;
      l[LB_RED] = b_r;
      l[LB_YEL] = b_y;
      l[LB_GRN] = b_g;
      return l;
   endfunction

   localparam logic [5:0] BG_L     = lamp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   localparam logic [5:0] BY_L     = lamp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   localparam logic [5:0] ALLRED_L = lamp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   localparam logic [5:0] AG_L     = lamp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   localparam logic [5:0] AY_L     = lamp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
   localparam logic [5:0] OFF_L    = 6'b000000;

endpackage

// File: rtl/phase_timer.sv
// Tick-driven phase duration counter.
// Ports: clk, clr (async active-low), tick (advance strobe), restart (zero the
// count, wins over tick), dur (current phase length in ticks), done (last tick
// of the phase), count (ticks elapsed in the current phase).
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             tick,
   input  logic             restart,
   input  logic [CNT_W-1:0] dur,
   output logic             done,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count_q <= '0;
      end else if (restart) begin
         count_q <= '0;
      end else if (tick) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign done  = tick && (count_q == dur - CNT_W'(1));
   assign count = count_q;

endmodule

// File: rtl/traffic_controller_ped.sv
// Two-road traffic-light controller with latched pedestrian request and WALK phase.
// Ports: clk, clr (async active-low), tick (phase-advance strobe), ped_req,
// night (flash-mode request), lights {A_r,A_y,A_g,B_r,B_y,B_g}, walk, phase
// (state code), ped_pend (request latched, not yet served).
// Build option: define NIGHT_FLASH_EN to enable the night flashing mode.
module traffic_controller_ped
   import traffic_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned GREEN_T   = 16,
   parameter int unsigned YELLOW_T  = 4,
   parameter int unsigned ALLRED_T  = 4,
   parameter int unsigned MIN_GREEN = 6,
   parameter int unsigned WALK_T    = 8
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       tick,
   input  logic       ped_req,
   input  logic       night,
   output logic [5:0] lights,
   output logic       walk,
   output logic [2:0] phase,
   output logic       ped_pend
);

   state_e           state_q, state_d;
   logic             next_a_q, next_a_d;
   logic             ped_pend_q, ped_pend_d;
   logic [CNT_W-1:0] dur, count;
   logic             done, restart, green_cut;

`ifdef NIGHT_FLASH_EN
   logic flash_q, flash_d;
`else
   logic unused_night;
   assign unused_night = night;
`endif

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk    (clk),
      .clr    (clr),
      .tick   (tick),
      .restart(restart),
      .dur    (dur),
      .done   (done),
      .count  (count)
   );

   always_comb begin
      dur = CNT_W'(ALLRED_T);
      case (state_q)
         StBg, StAg:   dur = CNT_W'(GREEN_T);
         StBy, StAy:   dur = CNT_W'(YELLOW_T);
         StAr1, StAr2: dur = CNT_W'(ALLRED_T);
         StPed:        dur = CNT_W'(WALK_T);
         default:      dur = CNT_W'(ALLRED_T);
      endcase
   end

   // A pending pedestrian may cut green short once the minimum green has run.
   assign green_cut = tick && ped_pend_q && (count >= CNT_W'(MIN_GREEN - 1));

   always_comb begin
      state_d  = state_q;
      next_a_d = next_a_q;
`ifdef NIGHT_FLASH_EN
      flash_d  = flash_q;
`endif
      case (state_q)
         StBg: if (done || green_cut) state_d = StBy;
         StBy: if (done) state_d = StAr1;
         StAr1: begin
            if (done) begin
               next_a_d = 1'b1;
               state_d  = ped_pend_q ? StPed : StAg;
`ifdef NIGHT_FLASH_EN
               if (night) state_d = StFlash;
`endif
            end
         end
         StAg: if (done || green_cut) state_d = StAy;
         StAy: if (done) state_d = StAr2;
         StAr2: begin
            if (done) begin
               next_a_d = 1'b0;
               state_d  = ped_pend_q ? StPed : StBg;
`ifdef NIGHT_FLASH_EN
               if (night) state_d = StFlash;
`endif
            end
         end
         StPed: if (done) state_d = next_a_q ? StAg : StBg;
         default: begin
`ifdef NIGHT_FLASH_EN
            if (tick) begin
               if (night) begin
                  flash_d = ~flash_q;
               end else begin
                  state_d  = StAr2;
                  next_a_d = 1'b0;
                  flash_d  = 1'b0;
               end
            end
`else
            // Code 7 is unreachable here; recover through an all-red phase.
            state_d = StAr2;
`endif
         end
      endcase
   end

   // Flash mode does not use the counter, so keep it parked at zero there.
   assign restart = (state_d != state_q) || (state_q == StFlash);

   always_comb begin
      ped_pend_d = ped_pend_q;
      if (state_d == StFlash) begin
         ped_pend_d = 1'b0;
      end else if ((state_d == StPed) && (state_q != StPed)) begin
         ped_pend_d = 1'b0;
      end else if (ped_req) begin
         ped_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= StBg;
         next_a_q   <= 1'b1;
         ped_pend_q <= 1'b0;
`ifdef NIGHT_FLASH_EN
         flash_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         next_a_q   <= next_a_d;
         ped_pend_q <= ped_pend_d;
`ifdef NIGHT_FLASH_EN
         flash_q    <= flash_d;
`endif
      end
   end

   always_comb begin
      lights = OFF_L;
      case (state_q)
         StBg:                lights = BG_L;
         StBy:                lights = BY_L;
         StAr1, StAr2, StPed: lights = ALLRED_L;
         StAg:                lights = AG_L;
         StAy:                lights = AY_L;
         default: begin
`ifdef NIGHT_FLASH_EN
            lights = flash_q ? AY_L : OFF_L;
`else
            lights = ALLRED_L;
`endif
         end
      endcase
   end

   assign walk     = (state_q == StPed);
   assign phase    = state_q;
   assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_traffic_controller_ped.sv
// Self-checking bench for traffic_controller_ped: a cycle model derived from the
// phase rules is compared every clock, plus directed run-length checks.
// Honours NIGHT_FLASH_EN for the night-mode scenario.
module tb_traffic_controller_ped;

   localparam int GT = 16;
   localparam int YT = 4;
   localparam int AT = 4;
   localparam int MG = 6;
   localparam int WT = 8;
`ifdef NIGHT_FLASH_EN
   localparam bit NE = 1'b1;
`else
   localparam bit NE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       tick = 1'b0;
   logic       ped_req = 1'b0;
   logic       night = 1'b0;
   logic [5:0] lights;
   logic       walk;
   logic [2:0] phase;
   logic       ped_pend;

   always #5 clk = ~clk;

   traffic_controller_ped #(
      .CNT_W    (8),
      .GREEN_T  (GT),
      .YELLOW_T (YT),
      .ALLRED_T (AT),
      .MIN_GREEN(MG),
      .WALK_T   (WT)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .tick    (tick),
      .ped_req (ped_req),
      .night   (night),
      .lights  (lights),
      .walk    (walk),
      .phase   (phase),
      .ped_pend(ped_pend)
   );

   int total = 0;
   int bad = 0;
   bit ped_lvl = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // ph: 0 BG,1 BY,2 AR1,3 AG,4 AY,5 AR2,6 PED,7 FLASH; cnt = ticks spent in phase
   typedef struct packed {
      int ph;
      int cnt;
      bit nexta;
      bit pend;
      bit flash;
   } mst_t;

   mst_t m;

   function automatic int dur_of(input int ph);
      case (ph)
         0, 3:    return GT;
         1, 4:    return YT;
         2, 5:    return AT;
         6:       return WT;
         default: return 1;
      endcase
   endfunction

   function automatic int model_lights(input mst_t s);
      case (s.ph)
         0:         return 'h21;
         1:         return 'h22;
         2, 5, 6:   return 'h24;
         3:         return 'h0C;
         4:         return 'h14;
         default:   return s.flash ? 'h14 : 'h00;
      endcase
   endfunction

   function automatic mst_t step(input mst_t s, input logic tk, input logic preq,
                                 input logic ngt);
      mst_t n;
      bit   fin;
      bit   green;
      n = s;
      if (tk) begin
         if (s.ph == 7) begin
            if (NE && ngt) begin
               n.flash = ~s.flash;
            end else begin
               n.ph    = 5;
               n.nexta = 1'b0;
               n.cnt   = 0;
               n.flash = 1'b0;
            end
         end else begin
            green = (s.ph == 0) || (s.ph == 3);
            fin   = (s.cnt == dur_of(s.ph) - 1) || (green && s.pend && s.cnt >= MG - 1);
            if (!fin) begin
               n.cnt = s.cnt + 1;
            end else begin
               n.cnt = 0;
               case (s.ph)
                  0: n.ph = 1;
                  1: n.ph = 2;
                  3: n.ph = 4;
                  4: n.ph = 5;
                  2: begin
                     n.nexta = 1'b1;
                     n.ph    = (NE && ngt) ? 7 : (s.pend ? 6 : 3);
                  end
                  5: begin
                     n.nexta = 1'b0;
                     n.ph    = (NE && ngt) ? 7 : (s.pend ? 6 : 0);
                  end
                  default: n.ph = s.nexta ? 3 : 0;
               endcase
            end
         end
      end
      if (n.ph == 7 || (n.ph == 6 && s.ph != 6)) n.pend = 1'b0;
      else if (preq) n.pend = 1'b1;
      return n;
   endfunction

   always @(posedge clk or negedge clr) begin
      if (!clr) m <= '{ph: 0, cnt: 0, nexta: 1'b1, pend: 1'b0, flash: 1'b0};
      else      m <= step(m, tick, ped_req, night);
   end

   always @(negedge clk) begin
      chk("cyc_lights", int'(lights), model_lights(m));
      chk("cyc_walk", int'(walk), int'(m.ph == 6));
      chk("cyc_phase", int'(phase), m.ph);
      chk("cyc_ped_pend", int'(ped_pend), int'(m.pend));
   end

   // ---------------- directed stimulus helpers ----------------
   logic [2:0] ph_q[$];
   logic [5:0] li_q[$];
   bit         wk_q[$];
   bit         pp_q[$];

   task automatic do_reset();
      clr     = 1'b0;
      tick    = 1'b0;
      ped_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
   endtask

   // Sample at each falling edge, then drive inputs for the following rising edge.
   task automatic record(input int n, input int ped_at, input int div);
      ph_q.delete();
      li_q.delete();
      wk_q.delete();
      pp_q.delete();
      for (int i = 0; i < n; i++) begin
         ph_q.push_back(phase);
         li_q.push_back(lights);
         wk_q.push_back(walk);
         pp_q.push_back(ped_pend);
         ped_req = ped_lvl || (i == ped_at);
         tick    = ((i % div) == div - 1);
         @(negedge clk);
      end
   endtask

   task automatic check_runs(input string nm, input int k, input int eph[8],
                             input int elen[8], input int eli[8]);
      int rp[$];
      int rl[$];
      int rli[$];
      for (int i = 0; i < ph_q.size(); i++) begin
         if (i == 0 || ph_q[i] != ph_q[i-1]) begin
            rp.push_back(int'(ph_q[i]));
            rl.push_back(1);
            rli.push_back(int'(li_q[i]));
         end else begin
            rl[rl.size()-1] = rl[rl.size()-1] + 1;
         end
      end
      for (int j = 0; j < k; j++) begin
         if (j < rp.size()) begin
            chk($sformatf("%s_run%0d_phase", nm, j), rp[j], eph[j]);
            chk($sformatf("%s_run%0d_len", nm, j), rl[j], elen[j]);
            chk($sformatf("%s_run%0d_lights", nm, j), rli[j], eli[j]);
         end else begin
            chk($sformatf("%s_run%0d_missing", nm, j), -1, eph[j]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 clr = 1'b0;
      #11;
      chk("rst_lights", int'(lights), 'h21);
      chk("rst_phase", int'(phase), 0);
      chk("rst_walk", int'(walk), 0);
      chk("rst_ped_pend", int'(ped_pend), 0);

      // 1: free-running cycle
      do_reset();
      record(60, -1, 1);
      check_runs("t1", 7, '{0, 1, 2, 3, 4, 5, 0, 0}, '{16, 4, 4, 16, 4, 4, 12, 0},
                 '{'h21, 'h22, 'h24, 'h0C, 'h14, 'h24, 'h21, 0});

      // 2: pedestrian pulse at BG count 2 cuts green at MIN_GREEN
      do_reset();
      record(25, 2, 1);
      check_runs("t2", 5, '{0, 1, 2, 6, 3, 0, 0, 0}, '{6, 4, 4, 8, 3, 0, 0, 0},
                 '{'h21, 'h22, 'h24, 'h24, 'h0C, 0, 0, 0});
      chk("t2_pend_before_ped", int'(pp_q[13]), 1);
      chk("t2_pend_on_ped", int'(pp_q[14]), 0);
      chk("t2_walk_on_ped", int'(wk_q[14]), 1);

      // 3: pedestrian at AG count 12
      do_reset();
      record(56, 36, 1);
      check_runs("t3", 8, '{0, 1, 2, 3, 4, 5, 6, 0}, '{16, 4, 4, 14, 4, 4, 8, 2},
                 '{'h21, 'h22, 'h24, 'h0C, 'h14, 'h24, 'h24, 'h21});

      // 4: tick every third clock; night is ignored unless the feature is built
      do_reset();
`ifndef NIGHT_FLASH_EN
      night = 1'b1;
`endif
      record(160, -1, 3);
      night = 1'b0;
      check_runs("t4", 6, '{0, 1, 2, 3, 4, 5, 0, 0}, '{48, 12, 12, 48, 12, 12, 0, 0},
                 '{'h21, 'h22, 'h24, 'h0C, 'h14, 'h24, 0, 0});

      // 5: asynchronous reset in AY count 2 with a request pending
      do_reset();
      record(42, 41, 1);
      ped_req = 1'b0;
      chk("t5_phase_before", int'(phase), 4);
      chk("t5_pend_before", int'(ped_pend), 1);
      #1 clr = 1'b0;
      #1;
      chk("t5_rst_lights", int'(lights), 'h21);
      chk("t5_rst_phase", int'(phase), 0);
      chk("t5_rst_pend", int'(ped_pend), 0);
      @(negedge clk);
      clr = 1'b1;
      record(20, -1, 1);
      check_runs("t5", 2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{16, 4, 0, 0, 0, 0, 0, 0},
                 '{'h21, 'h22, 0, 0, 0, 0, 0, 0});

`ifdef NIGHT_FLASH_EN
      // 6: night mode entered from AG, exits through AR2
      do_reset();
      record(30, -1, 1);
      night = 1'b1;
      record(18, -1, 1);
      chk("t6_start_ag", int'(ph_q[0]), 3);
      chk("t6_end_ar2", int'(ph_q[17]), 5);
      ped_lvl = 1'b1;
      record(10, -1, 1);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("t6_flash%0d_phase", k), int'(ph_q[k]), 7);
         chk($sformatf("t6_flash%0d_lights", k), int'(li_q[k]), (k % 2 == 1) ? 'h14 : 'h00);
         chk($sformatf("t6_flash%0d_pend", k), int'(pp_q[k]), 0);
      end
      ped_lvl = 1'b0;
      night   = 1'b0;
      record(12, -1, 1);
      check_runs("t6", 3, '{7, 5, 0, 0, 0, 0, 0, 0}, '{1, 4, 7, 0, 0, 0, 0, 0},
                 '{'h00, 'h24, 'h21, 0, 0, 0, 0, 0});
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
